count_event_monitor: RTL and testbench
======================================

Name: count_event_monitor

Overview:
- Sits directly downstream of the N-bit up/down counter.
- Each cycle it samples the counter output `q` and the direction control `ctrl`.
- Detects wrap-around, direction changes and crossings of a programmable threshold.
- Queues detected events in a small FIFO with a valid/ready output. Also keeps a saturating wrap count and a sticky overflow flag.

Parameters:
- N, 4, counter width; width of q_in, thresh and evt_value.
- DEPTH, 4, event FIFO depth; power of two, minimum 2.
- WCW, 8, width of wrap_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- q_in  input  N  counter value, sampled every clk.
- ctrl_in  input  1  counter direction (0 = up, 1 = down), sampled every clk.
- thresh  input  N  threshold for crossing detection; must be static while reset is low.
- clr_ovf  input  1  synchronous clear of overflow.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event.
- evt_code  output  3  head event code.
- evt_value  output  N  q_in value at the detecting edge.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- wrap_count  output  WCW  saturating count of wrap events.

Behaviour:
- Reset (synchronous, active-high), with the following values:
  - FIFO is flushed; evt_valid=0, evt_code=0, evt_value=0.
  - overflow=0, wrap_count=0.
  - Internal prev_valid=0.
  - Reset during operation discards all queued events the same edge.
- Sampling:
  - Registers q_prev, ctrl_prev and prev_valid update every edge.
  - prev_valid is set on the first edge after reset deasserts.
  - No event is detected while prev_valid=0. The first sample after reset never produces an event.
- Detection at edge k compares the current q_in/ctrl_in against q_prev/ctrl_prev. MAX = 2^N-1.
  - WRAP_UP, code 1: q_prev==MAX and q_in==0.
  - WRAP_DN, code 2: q_prev==0 and q_in==MAX.
  - DIR_CHG, code 3: ctrl_in != ctrl_prev.
  - THR_CROSS, code 4:
    - Either q_prev<thresh and q_in>=thresh,
    - or q_prev>=thresh and q_in<thresh.
    - Unsigned compare.
- Coincident events: at most one event is enqueued per cycle.
  - Priority: WRAP_UP/WRAP_DN, then DIR_CHG, then THR_CROSS.
  - Lower-priority coincident events are discarded silently and do not set overflow.
- wrap_count:
  - Increments on every WRAP_UP or WRAP_DN, whether or not the event is enqueued.
  - Saturates at 2^WCW-1; no wrap.
- FIFO:
  - First-word-fall-through. evt_code/evt_value show the head whenever evt_valid=1.
  - When evt_valid=0 they hold their last value (0 after reset).
  - Latency: an event detected at edge k gives evt_valid=1 after edge k, when the FIFO was empty.
  - Pop occurs when evt_valid && evt_ready at an edge.
  - Push occurs when an event is detected and either:
    - the FIFO is not full, or
    - the FIFO is full and a pop happens the same edge (push accepted, count unchanged).
  - Full with no pop: the event is dropped and overflow is set.
  - Pop when empty is ignored.
  - Events come out in strict detection order.
- overflow:
  - Cleared by clr_ovf=1.
  - A drop in the same cycle as clr_ovf wins: overflow=1.
- Non-wrap discontinuities are not wrap events. An example is q jumping to 0 because the counter was reset; only a threshold crossing may fire in that case.

Test Plan (N=4, DEPTH=4, WCW=8, thresh=8):
1. reset=1 for 2 cycles, then q_in=15, ctrl_in=0 held -> all outputs 0; no event on the first post-reset sample; evt_valid stays 0.
2. evt_ready=1, q_in counts 0..15,0 up -> THR_CROSS (4, value 8) at the 7->8 step; WRAP_UP (1, value 0) at the 15->0 step; wrap_count=1; each evt_valid pulse lasts exactly 1 cycle.
3. q_in=5 with ctrl_in 0->1 and q_in 5->4 -> one DIR_CHG (3, value 4).
4. evt_ready=0, force 5 distinct events -> 4 queued, overflow=1 after the 5th; evt_ready=1 drains them in detection order; clr_ovf=1 then clears overflow.
5. q_in 15->0 with ctrl_in toggling the same edge -> only WRAP_UP is queued; wrap_count increments; overflow stays 0.
6. FIFO full, evt_ready=1 and a new event on the same edge -> push accepted, FIFO stays full, overflow=0; then reset=1 mid-queue -> evt_valid=0 next cycle, wrap_count=0.

Source files
------------

// File: rtl/count_event_monitor.sv
// Event monitor for an up/down counter: detects wraps, direction changes and threshold
// crossings, queues them in a first-word-fall-through FIFO, and tracks wraps and drops.
module count_event_monitor #(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WCW   = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   q_in,
    input  logic           ctrl_in,
    input  logic [N-1:0]   thresh,
    input  logic           clr_ovf,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [2:0]     evt_code,
    output logic [N-1:0]   evt_value,
    output logic           overflow,
    output logic [WCW-1:0] wrap_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [N-1:0] QMax = '1;

    localparam logic [2:0] CodeWrapUp   = 3'd1;
    localparam logic [2:0] CodeWrapDn   = 3'd2;
    localparam logic [2:0] CodeDirChg   = 3'd3;
    localparam logic [2:0] CodeThrCross = 3'd4;

    logic [N-1:0]   q_prev_q, q_prev_d;
    logic           ctrl_prev_q, ctrl_prev_d;
    logic           prev_valid_q, prev_valid_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [2:0]     last_code_q, last_code_d;
    logic [N-1:0]   last_value_q, last_value_d;
    logic           overflow_q, overflow_d;
    logic [WCW-1:0] wrap_count_q, wrap_count_d;

    logic [2:0]     code_mem_q [DEPTH];
    logic [N-1:0]   value_mem_q [DEPTH];

    logic       wrap_up, wrap_dn, dir_chg, thr_cross;
    logic       det_valid;
    logic [2:0] det_code;
    logic       empty, full, pop, push, drop;

    always_comb begin
        wrap_up   = prev_valid_q && (q_prev_q == QMax) && (q_in == '0);
        wrap_dn   = prev_valid_q && (q_prev_q == '0) && (q_in == QMax);
        dir_chg   = prev_valid_q && (ctrl_in != ctrl_prev_q);
        thr_cross = prev_valid_q && ((q_prev_q < thresh) != (q_in < thresh));

        // Only the highest-priority coincident event is kept.
        det_valid = 1'b1;
        det_code  = 3'd0;
        if (wrap_up) begin
            det_code = CodeWrapUp;
        end else if (wrap_dn) begin
            det_code = CodeWrapDn;
        end else if (dir_chg) begin
            det_code = CodeDirChg;
        end else if (thr_cross) begin
            det_code = CodeThrCross;
        end else begin
            det_valid = 1'b0;
        end

        empty = (cnt_q == '0);
        full  = (cnt_q == (AW+1)'(DEPTH));
        pop   = !empty && evt_ready;
        push  = det_valid && (!full || pop);
        drop  = det_valid && full && !pop;

        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        // Outputs hold the last popped entry once the FIFO drains.
        last_code_d  = pop ? code_mem_q[rd_ptr_q]  : last_code_q;
        last_value_d = pop ? value_mem_q[rd_ptr_q] : last_value_q;

        overflow_d = drop || (overflow_q && !clr_ovf);

        wrap_count_d = wrap_count_q;
        if ((wrap_up || wrap_dn) && (wrap_count_q != '1)) begin
            wrap_count_d = wrap_count_q + WCW'(1);
        end

        q_prev_d     = q_in;
        ctrl_prev_d  = ctrl_in;
        prev_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev_q     <= '0;
            ctrl_prev_q  <= 1'b0;
            prev_valid_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            last_code_q  <= '0;
            last_value_q <= '0;
            overflow_q   <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            q_prev_q     <= q_prev_d;
            ctrl_prev_q  <= ctrl_prev_d;
            prev_valid_q <= prev_valid_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            last_code_q  <= last_code_d;
            last_value_q <= last_value_d;
            overflow_q   <= overflow_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    // Storage needs no reset: it is only observed through cnt_q.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            code_mem_q[wr_ptr_q]  <= det_code;
            value_mem_q[wr_ptr_q] <= q_in;
        end
    end

    always_comb begin
        evt_valid  = !empty;
        evt_code   = empty ? last_code_q  : code_mem_q[rd_ptr_q];
        evt_value  = empty ? last_value_q : value_mem_q[rd_ptr_q];
        overflow   = overflow_q;
        wrap_count = wrap_count_q;
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed self-checking bench for count_event_monitor (N=4, DEPTH=4, WCW=8, thresh=8).
module tb_count_event_monitor;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] q_in;
    logic       ctrl_in;
    logic [3:0] thresh;
    logic       clr_ovf;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [3:0] evt_value;
    logic       overflow;
    logic [7:0] wrap_count;

    int n_cmp  = 0;
    int n_fail = 0;

    count_event_monitor #(.N(4), .DEPTH(4), .WCW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .ctrl_in    (ctrl_in),
        .thresh     (thresh),
        .clr_ovf    (clr_ovf),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_value  (evt_value),
        .overflow   (overflow),
        .wrap_count (wrap_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; q_in = 4'd15; ctrl_in = 1'b0; thresh = 4'd8;
        evt_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", evt_valid); end
        n_cmp++; if (evt_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", evt_code); end
        n_cmp++; if (evt_value !== 4'd0) begin n_fail++; $display("FAIL reset_value got %0d exp 0", evt_value); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        n_cmp++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL reset_wrap got %0d exp 0", wrap_count); end
        reset = 1'b0;
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL first_sample_valid got %b exp 0", evt_valid); end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid got %b exp 0", evt_valid); end
    endtask

    task automatic test_count_up();
        logic       exp_v;
        logic [2:0] exp_c;
        // Reset then a first sample of 0 so the count starts 0..15,0 with no spurious wrap.
        reset = 1'b1; tick(); reset = 1'b0;
        evt_ready = 1'b1; q_in = 4'd0; ctrl_in = 1'b0;
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL up_first got %b exp 0", evt_valid); end
        for (int v = 1; v <= 16; v++) begin
            q_in = 4'(v);
            tick();
            exp_v = (v == 8) || (v == 16);
            exp_c = (v == 8) ? 3'd4 : 3'd1;
            n_cmp++;
            if (evt_valid !== exp_v) begin
                n_fail++; $display("FAIL up_valid step %0d got %b exp %b", v, evt_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (evt_code !== exp_c || evt_value !== 4'(v)) begin
                    n_fail++;
                    $display("FAIL up_event step %0d got %0d/%0d exp %0d/%0d",
                             v, evt_code, evt_value, exp_c, 4'(v));
                end
            end
            if (v == 9) begin
                n_cmp++;
                if (evt_code !== 3'd4 || evt_value !== 4'd8) begin
                    n_fail++; $display("FAIL up_hold got %0d/%0d exp 4/8", evt_code, evt_value);
                end
            end
        end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL up_wrap_pulse got %b exp 0", evt_valid); end
        n_cmp++; if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL up_wrap_count got %0d exp 1", wrap_count); end
    endtask

    task automatic test_dir_change();
        q_in = 4'd5; ctrl_in = 1'b0;
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL dir_pre got %b exp 0", evt_valid); end
        q_in = 4'd4; ctrl_in = 1'b1;
        tick();
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 3'd3 || evt_value !== 4'd4) begin
            n_fail++;
            $display("FAIL dir_event got %b/%0d/%0d exp 1/3/4", evt_valid, evt_code, evt_value);
        end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL dir_single got %b exp 0", evt_valid); end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_c [3] = '{3'd3, 3'd4, 3'd3};
        logic [3:0] exp_q [3] = '{4'd8, 4'd7, 4'd7};
        evt_ready = 1'b0;
        q_in = 4'd8; ctrl_in = 1'b1; tick();   // THR_CROSS 8
        ctrl_in = 1'b0; tick();                // DIR_CHG 8
        q_in = 4'd7; tick();                   // THR_CROSS 7
        ctrl_in = 1'b1; tick();                // DIR_CHG 7
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 3'd4 || evt_value !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full got %b/%0d/%0d ovf %b exp 1/4/8 ovf 0",
                     evt_valid, evt_code, evt_value, overflow);
        end
        q_in = 4'd9; tick();                   // THR_CROSS 9, dropped
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
        n_cmp++;
        if (evt_code !== 3'd4 || evt_value !== 4'd8) begin
            n_fail++; $display("FAIL ovf_head got %0d/%0d exp 4/8", evt_code, evt_value);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_code !== exp_c[i] || evt_value !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drain_%0d got %b/%0d/%0d exp 1/%0d/%0d",
                         i, evt_valid, evt_code, evt_value, exp_c[i], exp_q[i]);
            end
        end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", evt_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_coincident();
        q_in = 4'd15; ctrl_in = 1'b1;
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL coin_pre got %b exp 0", evt_valid); end
        q_in = 4'd0; ctrl_in = 1'b0;
        tick();
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 3'd1 || evt_value !== 4'd0) begin
            n_fail++;
            $display("FAIL coin_event got %b/%0d/%0d exp 1/1/0", evt_valid, evt_code, evt_value);
        end
        n_cmp++; if (wrap_count !== 8'd2) begin n_fail++; $display("FAIL coin_wrap got %0d exp 2", wrap_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL coin_ovf got %b exp 0", overflow); end
        tick();
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL coin_single got %b exp 0", evt_valid); end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        ctrl_in = 1'b1; tick();                // DIR_CHG 0
        q_in = 4'd8; tick();                   // THR_CROSS 8
        ctrl_in = 1'b0; tick();                // DIR_CHG 8
        q_in = 4'd7; tick();                   // THR_CROSS 7
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 3'd3 || evt_value !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_full got %b/%0d/%0d exp 1/3/0", evt_valid, evt_code, evt_value);
        end
        evt_ready = 1'b1; ctrl_in = 1'b1;      // pop and DIR_CHG 7 push together
        tick();
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_code !== 3'd4 || evt_value !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pushpop got %b/%0d/%0d ovf %b exp 1/4/8 ovf 0",
                     evt_valid, evt_code, evt_value, overflow);
        end
        evt_ready = 1'b0; q_in = 4'd9;         // still full: THR_CROSS dropped
        tick();
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_still_full got %b exp 1", overflow); end
        clr_ovf = 1'b1; q_in = 4'd7;           // drop and clear together
        tick();
        clr_ovf = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_drop_wins got %b exp 1", overflow); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b exp 0", evt_valid); end
        n_cmp++;
        if (evt_code !== 3'd0 || evt_value !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset_head got %0d/%0d exp 0/0", evt_code, evt_value);
        end
        n_cmp++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL mid_reset_wrap got %0d exp 0", wrap_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ovf got %b exp 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_dir_change();
        test_overflow();
        test_coincident();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
